// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, qualifies the synchronized lock flag,
// and releases system reset only after lock has held stable; retries on loss or timeout.
module pll_reset_seq #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_resetn,
    output logic       pll_ok,
    output logic [7:0] fault_cnt
);

    localparam int unsigned MAX_AB = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                     PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MAX_C  = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CNT_W  = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sync1_q;
    logic             lock_s_q;
    logic             pll_reset_q;
    logic             sys_resetn_q;
    logic             pll_ok_q;
    logic [7:0]       fault_q;

    // Two-flop synchronizer for the asynchronous lock flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= pll_lock;
            lock_s_q <= sync1_q;
        end
    end

    // Sequencer FSM; outputs are loaded together with the state they belong to
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= PLL_RST;
            cnt_q        <= '0;
            pll_reset_q  <= 1'b1;
            sys_resetn_q <= 1'b0;
            pll_ok_q     <= 1'b0;
            fault_q      <= 8'd0;
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_q     <= WAIT_LOCK;
                        cnt_q       <= '0;
                        pll_reset_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s_q) begin
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_q     <= PLL_RST;
                        cnt_q       <= '0;
                        pll_reset_q <= 1'b1;
                        if (fault_q != 8'hFF) fault_q <= fault_q + 8'd1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STABLE: begin
                    // A dropout here is treated as a glitch: requalify without a fault
                    if (!lock_s_q) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_q      <= RUN;
                        cnt_q        <= '0;
                        sys_resetn_q <= 1'b1;
                        pll_ok_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!lock_s_q) begin
                        state_q      <= PLL_RST;
                        cnt_q        <= '0;
                        pll_reset_q  <= 1'b1;
                        sys_resetn_q <= 1'b0;
                        pll_ok_q     <= 1'b0;
                        if (fault_q != 8'hFF) fault_q <= fault_q + 8'd1;
                    end
                end
                default: begin
                    state_q      <= PLL_RST;
                    cnt_q        <= '0;
                    pll_reset_q  <= 1'b1;
                    sys_resetn_q <= 1'b0;
                    pll_ok_q     <= 1'b0;
                end
            endcase
        end
    end

    assign pll_reset  = pll_reset_q;
    assign sys_resetn = sys_resetn_q;
    assign pll_ok     = pll_ok_q;
    assign fault_cnt  = fault_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed self-checking bench for pll_reset_seq with small parameters (4/8/32).
module tb_pll_reset_seq;

    logic       clk;
    logic       resetn;
    logic       pll_lock;
    logic       pll_reset;
    logic       sys_resetn;
    logic       pll_ok;
    logic [7:0] fault_cnt;

    int n_cmp;
    int n_err;

    pll_reset_seq #(
        .PLL_RST_CYCLES     (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(32)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .pll_lock  (pll_lock),
        .pll_reset (pll_reset),
        .sys_resetn(sys_resetn),
        .pll_ok    (pll_ok),
        .fault_cnt (fault_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One rising edge, then settle at the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Hold reset across two edges, release at a falling edge
    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        steps(2);
        resetn = 1'b1;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        resetn   = 1'b0;
        pll_lock = 1'b0;
        steps(3);
        chk("rst_pll_reset", 32'(pll_reset), 32'd1);
        chk("rst_sys_resetn", 32'(sys_resetn), 32'd0);
        chk("rst_pll_ok", 32'(pll_ok), 32'd0);
        chk("rst_fault", 32'(fault_cnt), 32'd0);

        // Power-up
        resetn = 1'b1;
        steps(3);
        chk("pu_pll_reset_e3", 32'(pll_reset), 32'd1);
        step();
        chk("pu_pll_reset_e4", 32'(pll_reset), 32'd0);
        steps(9);
        pll_lock = 1'b1;
        step();
        steps(9);
        chk("pu_sys_e9", 32'(sys_resetn), 32'd0);
        chk("pu_ok_e9", 32'(pll_ok), 32'd0);
        step();
        chk("pu_sys_e10", 32'(sys_resetn), 32'd1);
        chk("pu_ok_e10", 32'(pll_ok), 32'd1);
        chk("pu_fault", 32'(fault_cnt), 32'd0);

        // Lock loss in RUN, then relock
        pll_lock = 1'b0;
        steps(2);
        chk("loss_sys_f1", 32'(sys_resetn), 32'd1);
        step();
        chk("loss_sys_f2", 32'(sys_resetn), 32'd0);
        chk("loss_ok_f2", 32'(pll_ok), 32'd0);
        chk("loss_pll_reset_f2", 32'(pll_reset), 32'd1);
        chk("loss_fault_f2", 32'(fault_cnt), 32'd1);
        steps(3);
        chk("loss_pll_reset_f5", 32'(pll_reset), 32'd1);
        step();
        chk("loss_pll_reset_f6", 32'(pll_reset), 32'd0);
        pll_lock = 1'b1;
        step();
        steps(9);
        chk("relock_sys_e9", 32'(sys_resetn), 32'd0);
        step();
        chk("relock_sys_e10", 32'(sys_resetn), 32'd1);
        chk("relock_fault", 32'(fault_cnt), 32'd1);

        // Second loss, then async reset while in STABLE
        pll_lock = 1'b0;
        steps(3);
        chk("loss2_fault", 32'(fault_cnt), 32'd2);
        steps(4);
        chk("loss2_pll_reset", 32'(pll_reset), 32'd0);
        pll_lock = 1'b1;
        steps(5);
        chk("stable_pll_reset", 32'(pll_reset), 32'd0);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_pll_reset", 32'(pll_reset), 32'd1);
        chk("async_sys", 32'(sys_resetn), 32'd0);
        chk("async_ok", 32'(pll_ok), 32'd0);
        chk("async_fault", 32'(fault_cnt), 32'd0);
        @(negedge clk);
        steps(2);
        resetn = 1'b1;
        // Lock already high: ignored during PLL_RST, run follows at edge 13
        steps(3);
        chk("restart_pll_reset_e3", 32'(pll_reset), 32'd1);
        step();
        chk("restart_pll_reset_e4", 32'(pll_reset), 32'd0);
        steps(8);
        chk("restart_sys_e12", 32'(sys_resetn), 32'd0);
        step();
        chk("restart_sys_e13", 32'(sys_resetn), 32'd1);

        // Lock glitch in STABLE
        pll_lock = 1'b0;
        do_reset();
        steps(4);
        pll_lock = 1'b1;
        steps(5);
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        step();
        steps(2);
        chk("glitch_pll_reset_h2", 32'(pll_reset), 32'd0);
        steps(7);
        chk("glitch_sys_h9", 32'(sys_resetn), 32'd0);
        step();
        chk("glitch_sys_h10", 32'(sys_resetn), 32'd1);
        chk("glitch_pll_reset_h10", 32'(pll_reset), 32'd0);
        chk("glitch_fault", 32'(fault_cnt), 32'd0);

        // Lock reaches lock_s exactly on the last WAIT_LOCK edge
        pll_lock = 1'b0;
        do_reset();
        steps(33);
        pll_lock = 1'b1;
        steps(3);
        chk("simul_pll_reset_e36", 32'(pll_reset), 32'd0);
        chk("simul_fault_e36", 32'(fault_cnt), 32'd0);
        steps(7);
        chk("simul_sys_e43", 32'(sys_resetn), 32'd0);
        step();
        chk("simul_sys_e44", 32'(sys_resetn), 32'd1);
        chk("simul_fault_e44", 32'(fault_cnt), 32'd0);

        // Timeout retries and fault saturation
        pll_lock = 1'b0;
        do_reset();
        for (int e = 1; e <= 36 * 256; e++) begin
            step();
            if (e == 35) begin
                chk("to_pll_reset_e35", 32'(pll_reset), 32'd0);
                chk("to_fault_e35", 32'(fault_cnt), 32'd0);
            end
            if (e == 36) begin
                chk("to_pll_reset_e36", 32'(pll_reset), 32'd1);
                chk("to_fault_e36", 32'(fault_cnt), 32'd1);
            end
            if (e == 39) chk("to_pll_reset_e39", 32'(pll_reset), 32'd1);
            if (e == 40) chk("to_pll_reset_e40", 32'(pll_reset), 32'd0);
            if (e == 72) begin
                chk("to_pll_reset_e72", 32'(pll_reset), 32'd1);
                chk("to_fault_e72", 32'(fault_cnt), 32'd2);
            end
            if (e == 36 * 255 - 1) chk("to_fault_254", 32'(fault_cnt), 32'd254);
            if (e == 36 * 255) chk("to_fault_255", 32'(fault_cnt), 32'd255);
            if (e == 36 * 256) begin
                chk("to_fault_sat", 32'(fault_cnt), 32'd255);
                chk("to_pll_reset_sat", 32'(pll_reset), 32'd1);
                chk("to_sys_sat", 32'(sys_resetn), 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
